glyph_bitmap_rom: RTL and testbench

//  Synchronous 1-bit-wide bitmap ROM of 32x32-pixel glyphs for the VGA overlay.
//  One module, three contents selected by parameter:
//  - score digits 0-F (replaces Score_ROM);
//  - the "PLAYEr 1" win banner (replaces P1_ROM);
//  - the "PLAYEr 2" win banner (replaces P2_ROM).

---
 rtl/glyph_bitmap_rom.sv | 107 ++++++++++
 tb/tb_glyph_bitmap_rom.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/glyph_bitmap_rom.sv
// glyph_bitmap_rom
// 1-bit-wide bitmap ROM of 32x32-pixel seven-segment glyphs for the VGA overlay.
// CONTENT selects the glyph set: hex score digits, "PLAYEr 1" or "PLAYEr 2".
// Pixels are computed from a segment table, so no init file is needed.
// Read latency is one cycle; only the output pixel is registered.

module glyph_bitmap_rom #(
  parameter int CONTENT    = 0,
  parameter int GLYPH_BITS = (CONTENT == 0) ? 4 : 3,
  parameter int ADDR_W     = 10 + GLYPH_BITS
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [ADDR_W-1:0] addra,
  output logic              douta
);

  // Address fields: {row, glyph, col}
  logic [4:0]            w_row;
  logic [4:0]            w_col;
  logic [GLYPH_BITS-1:0] w_glyph;
  logic [3:0]            w_glyphIdx;
  logic [6:0]            w_seg;

  logic w_rowA, w_rowUpper, w_rowG, w_rowLower, w_rowD;
  logic w_colLeft, w_colMid, w_colRight;
  logic w_lit;

  logic r_pixel;

  assign w_row   = addra[ADDR_W-1 -: 5];
  assign w_glyph = addra[5 +: GLYPH_BITS];
  assign w_col   = addra[4:0];

  // Widen the glyph index to 4 bits so one table serves every content set
  always_comb begin
    w_glyphIdx = '0;
    w_glyphIdx[GLYPH_BITS-1:0] = w_glyph;
  end

  // Glyph-to-segment-code table, seg = {g,f,e,d,c,b,a}
  always_comb begin
    w_seg = 7'h00;
    if (CONTENT == 0) begin
      case (w_glyphIdx)
        4'h0: w_seg = 7'h3F;
        4'h1: w_seg = 7'h06;
        4'h2: w_seg = 7'h5B;
        4'h3: w_seg = 7'h4F;
        4'h4: w_seg = 7'h66;
        4'h5: w_seg = 7'h6D;
        4'h6: w_seg = 7'h7D;
        4'h7: w_seg = 7'h07;
        4'h8: w_seg = 7'h7F;
        4'h9: w_seg = 7'h6F;
        4'hA: w_seg = 7'h77;
        4'hB: w_seg = 7'h7C;
        4'hC: w_seg = 7'h39;
        4'hD: w_seg = 7'h5E;
        4'hE: w_seg = 7'h79;
        default: w_seg = 7'h71;
      endcase
    end else begin
      case (w_glyphIdx)
        4'h0: w_seg = 7'h73;
        4'h1: w_seg = 7'h38;
        4'h2: w_seg = 7'h77;
        4'h3: w_seg = 7'h6E;
        4'h4: w_seg = 7'h79;
        4'h5: w_seg = 7'h50;
        4'h6: w_seg = 7'h00;
        4'h7: w_seg = (CONTENT == 2) ? 7'h5B : 7'h06;
        default: w_seg = 7'h00;
      endcase
    end
  end

  // Row and column bands that the seven segments occupy
  assign w_rowA     = (w_row >= 5'd2)  && (w_row <= 5'd5);
  assign w_rowUpper = (w_row >= 5'd6)  && (w_row <= 5'd13);
  assign w_rowG     = (w_row >= 5'd14) && (w_row <= 5'd17);
  assign w_rowLower = (w_row >= 5'd18) && (w_row <= 5'd25);
  assign w_rowD     = (w_row >= 5'd26) && (w_row <= 5'd29);
  assign w_colLeft  = (w_col >= 5'd4)  && (w_col <= 5'd7);
  assign w_colMid   = (w_col >= 5'd8)  && (w_col <= 5'd23);
  assign w_colRight = (w_col >= 5'd24) && (w_col <= 5'd27);

  assign w_lit = (w_seg[0] && w_rowA     && w_colMid)   ||
                 (w_seg[1] && w_rowUpper && w_colRight) ||
                 (w_seg[2] && w_rowLower && w_colRight) ||
                 (w_seg[3] && w_rowD     && w_colMid)   ||
                 (w_seg[4] && w_rowLower && w_colLeft)  ||
                 (w_seg[5] && w_rowUpper && w_colLeft)  ||
                 (w_seg[6] && w_rowG     && w_colMid);

  // Register the pixel; reset forces background regardless of address
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= w_lit;
    end
  end

  assign douta = r_pixel;

endmodule

// File: tb/tb_glyph_bitmap_rom.sv
// tb_glyph_bitmap_rom
// Drives all three content variants side by side and checks every registered
// pixel against a rectangle-table model, plus hand-computed directed pixels.

module tb_glyph_bitmap_rom;

  logic        clk;
  logic        rst;
  logic [13:0] addr0;
  logic [12:0] addr1;
  logic [12:0] addr2;
  logic        dout0, dout1, dout2;

  int checks = 0;
  int errors = 0;

  // Segment rectangles in order a,b,c,d,e,f,g (inclusive bounds)
  localparam int SEG_R_LO[7] = '{2, 6, 18, 26, 18, 6, 14};
  localparam int SEG_R_HI[7] = '{5, 13, 25, 29, 25, 13, 17};
  localparam int SEG_C_LO[7] = '{8, 24, 24, 8, 4, 4, 8};
  localparam int SEG_C_HI[7] = '{23, 27, 27, 23, 7, 7, 23};
  localparam int HEX_CODES[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  localparam int BANNER_CODES[8] = '{'h73, 'h38, 'h77, 'h6E, 'h79, 'h50, 'h00, 'h06};

  glyph_bitmap_rom #(.CONTENT(0)) dutScore (.clka(clk), .rsta(rst), .addra(addr0), .douta(dout0));
  glyph_bitmap_rom #(.CONTENT(1)) dutP1    (.clka(clk), .rsta(rst), .addra(addr1), .douta(dout1));
  glyph_bitmap_rom #(.CONTENT(2)) dutP2    (.clka(clk), .rsta(rst), .addra(addr2), .douta(dout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model(input int content, input int glyph, input int row, input int col);
    int code;
    if (content == 0) code = HEX_CODES[glyph];
    else if (content == 2 && glyph == 7) code = 'h5B;
    else code = BANNER_CODES[glyph];
    for (int s = 0; s < 7; s++) begin
      if (code[s] && row >= SEG_R_LO[s] && row <= SEG_R_HI[s] &&
          col >= SEG_C_LO[s] && col <= SEG_C_HI[s])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [13:0] scoreAddr(input int glyph, input int row, input int col);
    logic [4:0] r, c;
    logic [3:0] g;
    r = row[4:0]; c = col[4:0]; g = glyph[3:0];
    return {r, g, c};
  endfunction

  function automatic logic [12:0] bannerAddr(input int glyph, input int row, input int col);
    logic [4:0] r, c;
    logic [2:0] g;
    r = row[4:0]; c = col[4:0]; g = glyph[2:0];
    return {r, g, c};
  endfunction

  // Expected outputs captured at each rising edge from the sampled inputs
  bit expPix[3];
  bit haveExp = 1'b0;

  always @(posedge clk) begin
    expPix[0] = rst ? 1'b0 : model(0, int'(addr0[8:5]), int'(addr0[13:9]), int'(addr0[4:0]));
    expPix[1] = rst ? 1'b0 : model(1, int'(addr1[7:5]), int'(addr1[12:8]), int'(addr1[4:0]));
    expPix[2] = rst ? 1'b0 : model(2, int'(addr2[7:5]), int'(addr2[12:8]), int'(addr2[4:0]));
    haveExp = 1'b1;
  end

  // Compare every DUT against the model on the falling edge
  always @(negedge clk) begin
    if (haveExp) begin
      checks++;
      if (dout0 !== expPix[0]) begin
        errors++;
        $display("[TB] FAIL model_score t=%0t got=%b expected=%b", $time, dout0, expPix[0]);
      end
      checks++;
      if (dout1 !== expPix[1]) begin
        errors++;
        $display("[TB] FAIL model_p1 t=%0t got=%b expected=%b", $time, dout1, expPix[1]);
      end
      checks++;
      if (dout2 !== expPix[2]) begin
        errors++;
        $display("[TB] FAIL model_p2 t=%0t got=%b expected=%b", $time, dout2, expPix[2]);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [13:0] a0,
                               input logic [12:0] a1, input logic [12:0] a2);
    @(negedge clk);
    rst   = r;
    addr0 = a0;
    addr1 = a1;
    addr2 = a2;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%b expected=%b", name, actual, expected);
    end
  endtask

  initial begin
    rst   = 1'b1;
    addr0 = '0;
    addr1 = '0;
    addr2 = '0;
    repeat (2) @(posedge clk);

    // Reset dominates a lit pixel, then data follows one edge after release
    applyStimulus(1'b1, scoreAddr(8, 3, 10), bannerAddr(7, 20, 26), bannerAddr(7, 20, 5));
    checkOutput("reset_score", dout0, 1'b0);
    checkOutput("reset_p1", dout1, 1'b0);
    checkOutput("reset_p2", dout2, 1'b0);
    applyStimulus(1'b0, scoreAddr(8, 3, 10), bannerAddr(7, 20, 26), bannerAddr(7, 20, 5));
    checkOutput("release_score", dout0, 1'b1);
    checkOutput("release_p1", dout1, 1'b1);
    checkOutput("release_p2", dout2, 1'b1);

    // Digit 8 corner, digit 1 segments, banner glyph 7 differences
    applyStimulus(1'b0, scoreAddr(8, 3, 5), bannerAddr(7, 20, 5), bannerAddr(7, 20, 26));
    checkOutput("g8_corner", dout0, 1'b0);
    checkOutput("p1_g7_r20c5", dout1, 1'b0);
    checkOutput("p2_g7_r20c26", dout2, 1'b0);
    applyStimulus(1'b0, scoreAddr(1, 10, 25), bannerAddr(0, 3, 10), bannerAddr(7, 15, 15));
    checkOutput("g1_r10c25", dout0, 1'b1);
    checkOutput("p1_g0_r3c10", dout1, 1'b1);
    checkOutput("p2_g7_r15c15", dout2, 1'b1);
    applyStimulus(1'b0, scoreAddr(1, 3, 15), bannerAddr(5, 20, 5), bannerAddr(6, 15, 15));
    checkOutput("g1_r3c15", dout0, 1'b0);
    checkOutput("p1_g5_r20c5", dout1, 1'b1);
    checkOutput("p2_g6_blank", dout2, 1'b0);
    applyStimulus(1'b0, scoreAddr(1, 15, 12), bannerAddr(5, 20, 26), bannerAddr(7, 27, 15));
    checkOutput("g1_r15c12", dout0, 1'b0);
    checkOutput("p1_g5_r20c26", dout1, 1'b0);
    checkOutput("p2_g7_r27c15", dout2, 1'b1);

    // Blank banner glyph is background everywhere
    for (int p = 0; p < 1024; p++) begin
      applyStimulus(1'b0, scoreAddr(0, p / 32, p % 32), bannerAddr(6, p / 32, p % 32),
                    bannerAddr(6, p / 32, p % 32));
      checkOutput("p1_g6_blank", dout1, 1'b0);
    end

    // Back-to-back sweep of every address; banners wrap through twice
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      addr0 = i[13:0];
      addr1 = i[12:0];
      addr2 = i[12:0];
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
